// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a 32-bit Wishbone-classic slave,
// with an optional prescaler and a registered timer-interrupt-pending output.
module serv_mtimer #(
  parameter int DIV            = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q, cmp_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      rdat_q, rdat_d;
  logic             ack_q;
  logic             mtip_q;
  logic             tick;
  logic             accept;
  logic             wr0, wr1, wr2, wr3, rd0;
  logic [32:0]      lo_inc;

  generate
    if (DIV == 1) begin : g_notick
      assign tick = 1'b1;
    end else begin : g_tick
      assign tick = (pre_q == PRE_MAX);
    end
  endgenerate

  // The pending ack blocks acceptance, so each request is seen exactly once.
  assign accept = i_wb_cyc & ~ack_q;
  assign wr0    = accept & i_wb_we  & (i_wb_adr == 2'd0);
  assign wr1    = accept & i_wb_we  & (i_wb_adr == 2'd1);
  assign wr2    = accept & i_wb_we  & (i_wb_adr == 2'd2);
  assign wr3    = accept & i_wb_we  & (i_wb_adr == 2'd3);
  assign rd0    = accept & ~i_wb_we & (i_wb_adr == 2'd0);
  assign lo_inc = {1'b0, mtime_q[31:0]} + 33'(tick);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    mtime_d  = mtime_q + 64'(tick);
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    rdat_d   = rdat_q;

    if (wr0 | wr1)
      pre_d = '0;

    // A write owns its half; on a high-half write the low-half carry is dropped.
    if (wr0)
      mtime_d = {mtime_q[63:32], i_wb_dat};
    else if (wr1)
      mtime_d = {i_wb_dat, lo_inc[31:0]};

    if (wr2)
      cmp_d[31:0] = i_wb_dat;
    if (wr3)
      cmp_d[63:32] = i_wb_dat;

    // Latch the high half alongside a low read so a lo/hi pair is coherent.
    if (rd0)
      shadow_d = mtime_q[63:32];

    if (accept) begin
      case (i_wb_adr)
        2'd0:    rdat_d = mtime_q[31:0];
        2'd1:    rdat_d = shadow_q;
        2'd2:    rdat_d = cmp_q[31:0];
        default: rdat_d = cmp_q[63:32];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q    <= '0;
      mtime_q  <= '0;
      cmp_q    <= '1;
      shadow_q <= '0;
      rdat_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdat_q   <= rdat_d;
    end
  end

  generate
    if (RESET_STRATEGY == "NONE") begin : g_norst
      always_ff @(posedge i_clk) begin
        ack_q  <= accept;
        mtip_q <= (mtime_q >= cmp_q);
      end
    end else begin : g_rst
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ack_q  <= 1'b0;
          mtip_q <= 1'b0;
        end else begin
          ack_q  <= accept;
          mtip_q <= (mtime_q >= cmp_q);
        end
      end
    end
  endgenerate

  assign o_wb_dat = rdat_q;
  assign o_wb_ack = ack_q;
  assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer: a DIV=1 instance for bus/counter/interrupt
// behaviour and a DIV=4 instance for the prescaler.
module tb_serv_mtimer;

  logic        clk = 1'b0;
  logic        rst1, rst4;
  logic        sel;
  logic        cyc, we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic        cyc1, cyc4;
  logic [31:0] dat1, dat4;
  logic        ack1, ack4, mtip1, mtip4;
  logic [31:0] rdat_mux;
  logic        ack_mux, mtip_mux;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign cyc1     = cyc & ~sel;
  assign cyc4     = cyc & sel;
  assign rdat_mux = sel ? dat4 : dat1;
  assign ack_mux  = sel ? ack4 : ack1;
  assign mtip_mux = sel ? mtip4 : mtip1;

  serv_mtimer #(.DIV(1)) dut (
    .i_clk(clk), .i_rst(rst1), .i_wb_cyc(cyc1), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .o_wb_dat(dat1), .o_wb_ack(ack1), .o_mtip(mtip1)
  );

  serv_mtimer #(.DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_wb_cyc(cyc4), .i_wb_we(we), .i_wb_adr(adr),
    .i_wb_dat(wdat), .o_wb_dat(dat4), .o_wb_ack(ack4), .o_mtip(mtip4)
  );

  typedef struct {
    bit          we;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  logic [31:0] rd;
  logic        mtip_at_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One transaction: accepted at the next posedge, ack sampled at the following
  // negedge, then one idle cycle so the next call is never blocked by ack.
  task automatic bus(input bit s, input bit w, input logic [1:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    sel  = s;
    cyc  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    @(posedge clk);
    @(negedge clk);
    chk("ack", ack_mux, 1);
    r           = rdat_mux;
    mtip_at_ack = mtip_mux;
    cyc = 1'b0;
    we  = 1'b0;
    $display("bus dut%0d %s adr=%0d wdat=%08h rdat=%08h", s ? 4 : 1, w ? "WR" : "RD", a, d, r);
    @(negedge clk);
    chk("ack_single", ack_mux, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;

    vecs[0]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[1]  = '{1'b1, 2'd2, 32'hAAAA_5555, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'hAAAA_5555};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'hFFFF_FFFF};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_0007, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 32'hFFFF_FFFE, 32'h0};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,         32'hFFFF_FFFF};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0007};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0003};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0008};
    vecs[10] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000};
    vecs[13] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000};
    vecs[14] = '{1'b1, 2'd0, 32'h0000_1234, 32'h0};
    vecs[15] = '{1'b0, 2'd0, 32'h0,         32'h0000_1235};

    rst1 = 1'b1;
    rst4 = 1'b1;
    sel  = 1'b0;
    cyc  = 1'b0;
    we   = 1'b0;
    adr  = 2'd0;
    wdat = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack1, 0);
    chk("rst_dat", dat1, 0);
    chk("rst_mtip", mtip1, 0);
    chk("rst_ack4", ack4, 0);

    // Count from reset: ten edges after release mtime is 10
    rst1 = 1'b0;
    repeat (10) @(negedge clk);
    bus(0, 0, 2'd0, 0, rd); chk("count10", rd, 32'd10);
    chk("count_mtip", mtip1, 0);
    bus(0, 0, 2'd1, 0, rd); chk("rst_shadow", rd, 32'h0);
    bus(0, 0, 2'd2, 0, rd); chk("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(0, 0, 2'd3, 0, rd); chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);

    foreach (vecs[i]) begin
      bus(0, vecs[i].we, vecs[i].adr, vecs[i].dat, rd);
      if (!vecs[i].we)
        chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Interrupt rise: mtime=0 at C+4, cmp=30, mtip rises one edge after mtime==30
    bus(0, 1, 2'd2, 32'd30, rd);
    bus(0, 1, 2'd1, 32'd0, rd);
    bus(0, 1, 2'd0, 32'd0, rd);
    bus(0, 1, 2'd3, 32'd0, rd);
    chk("irq_low_early", mtip1, 0);
    repeat (27) @(negedge clk);
    chk("irq_at_equal", mtip1, 0);
    @(negedge clk);
    chk("irq_rise", mtip1, 1);
    bus(0, 1, 2'd3, 32'hFFFF_FFFF, rd);
    chk("irq_still_high", mtip_at_ack, 1);
    chk("irq_fall", mtip1, 0);

    // mtimecmp = 0 with mtime = 0 still asserts (>=)
    bus(0, 1, 2'd3, 32'd0, rd);
    bus(0, 1, 2'd2, 32'd0, rd);
    bus(0, 1, 2'd0, 32'd0, rd);
    chk("cmp0_eq", mtip1, 1);
    repeat (5) @(negedge clk);
    chk("cmp0_hold", mtip1, 1);

    // Held request: 6 cycles give exactly 3 acks
    sel = 1'b0; cyc = 1'b1; we = 1'b0; adr = 2'd2;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack1) acks++;
    end
    cyc = 1'b0;
    chk("hs_acks", acks, 3);
    @(negedge clk);
    chk("hs_idle", ack1, 0);

    // Reset in the acceptance cycle of a write to mtimecmp low
    rst1 = 1'b1; cyc = 1'b1; we = 1'b1; adr = 2'd2; wdat = 32'h55;
    @(posedge clk);
    @(negedge clk);
    chk("rst_acc_ack", ack1, 0);
    chk("rst_acc_mtip", mtip1, 0);
    rst1 = 1'b0; cyc = 1'b0; we = 1'b0;
    bus(0, 0, 2'd2, 0, rd); chk("rst_acc_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(0, 0, 2'd3, 0, rd); chk("rst_acc_cmp_hi", rd, 32'hFFFF_FFFF);

    // Prescaler DIV=4: 40 edges after reset gives mtime 10
    sel  = 1'b1;
    rst4 = 1'b0;
    repeat (40) @(negedge clk);
    bus(1, 0, 2'd0, 0, rd); chk("div4_count", rd, 32'd10);
    bus(1, 1, 2'd0, 32'd0, rd);
    repeat (2) @(negedge clk);
    bus(1, 0, 2'd0, 0, rd); chk("div4_before_tick", rd, 32'd0);
    bus(1, 1, 2'd0, 32'd0, rd);
    repeat (3) @(negedge clk);
    bus(1, 0, 2'd0, 0, rd); chk("div4_tick_at_4", rd, 32'd1);
    chk("div4_mtip", mtip4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
